// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for the convolution result writer
// Exports state_t (IDLE/CAPTURE/DRAIN), fifo_entry_t (default-width {addr, data}), saturate().
package conv_pkg;
   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
   localparam int CONV_ADDR_WIDTH = 19;
   localparam int CONV_OUT_WIDTH = 12;
   typedef struct packed {
      logic [CONV_ADDR_WIDTH-1:0] addr;
      logic [CONV_OUT_WIDTH-1:0]  data;
   } fifo_entry_t;
   function automatic logic [31:0] saturate(input logic [31:0] v, input int w);
      return (v >> w) != 0 ? 32'((64'd1 << w) - 64'd1) : v;
   endfunction
endpackage

// File: rtl/conv_result_writer_sync_fifo.sv
// sync_fifo: single-clock FIFO, WIDTH bits x DEPTH entries (power of 2)
// Ports: clk, rst (sync active-high), push/wr_data in, pop in, rd_data (head, 0 when empty), full, empty, count.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0] cnt_q, cnt_d;
   logic do_push, do_pop;
   always_comb begin
      do_pop = pop && !empty;
      do_push = push && (!full || do_pop);
      mem_d = mem_q;
      if (do_push) mem_d[wr_q] = wr_data;
      wr_d = do_push ? wr_q + AW'(1) : wr_q;
      rd_d = do_pop ? rd_q + AW'(1) : rd_q;
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
      end
      mem_q <= mem_d;
   end
   assign empty = cnt_q == '0;
   assign full = cnt_q == (AW+1)'(DEPTH);
   assign count = cnt_q;
   assign rd_data = empty ? '0 : mem_q[rd_q];
endmodule

// File: rtl/conv_result_writer.sv
// conv_result_writer: crops the convolution border, saturates, and queues writes to a frame buffer
// Ports: i_clk, i_rst (sync active-high); i_start arms one frame; i_val_valid/i_val magnitude stream;
// o_mem_wr_valid/i_mem_wr_ready/o_mem_wr_addr/o_mem_wr_data write port; o_busy, o_frame_done, o_overflow status.
module conv_result_writer
   import conv_pkg::*;
#(
   parameter int N          = 3,
   parameter int DATA_WIDTH = 12,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int OUT_WIDTH  = 12,
   parameter int ADDR_WIDTH = 19,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic                    i_val_valid,
   input  logic [DATA_WIDTH+2:0]   i_val,
   output logic                    o_mem_wr_valid,
   input  logic                    i_mem_wr_ready,
   output logic [ADDR_WIDTH-1:0]   o_mem_wr_addr,
   output logic [OUT_WIDTH-1:0]    o_mem_wr_data,
   output logic                    o_busy,
   output logic                    o_frame_done,
   output logic                    o_overflow
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam int FW = $clog2(FIFO_DEPTH);
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [OUT_WIDTH-1:0]  data;
   } entry_t;
   state_t state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic ovf_q, ovf_d;
   logic accept, keep, last, eol, clear, push, pop, full, empty;
   logic [OUT_WIDTH-1:0] sat_val;
   logic [FW:0] count;
   entry_t head;
   sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(i_clk),
      .rst(i_rst),
      .push(push),
      .pop(pop),
      .wr_data({addr_q, sat_val}),
      .rd_data(head),
      .full(full),
      .empty(empty),
      .count(count)
   );
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         col_q <= '0;
         row_q <= '0;
         addr_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q <= col_d;
         row_q <= row_d;
         addr_q <= addr_d;
         ovf_q <= ovf_d;
      end
   end
   always_comb begin
      state_d = state_q == IDLE    ? (i_start ? CAPTURE : IDLE) :
                state_q == CAPTURE ? (last ? DRAIN : CAPTURE) :
                                     (count == '0 ? IDLE : DRAIN);
   end
   // The address advances on every kept sample, even a dropped one, so later writes stay in place.
   always_comb begin
      accept = state_q == CAPTURE && i_val_valid;
      eol = col_q == CW'(IMG_WIDTH - 1);
      keep = accept && row_q >= RW'(N - 1) && col_q >= CW'(N - 1);
      last = accept && eol && row_q == RW'(IMG_HEIGHT - 1);
      clear = state_q == IDLE && i_start;
      push = keep && (!full || pop);
      sat_val = OUT_WIDTH'(saturate(32'(i_val), OUT_WIDTH));
      col_d = clear ? '0 : accept ? (eol ? '0 : col_q + CW'(1)) : col_q;
      row_d = clear ? '0 : accept && eol ? row_q + RW'(1) : row_q;
      addr_d = clear ? '0 : keep ? addr_q + ADDR_WIDTH'(1) : addr_q;
      ovf_d = !clear && (ovf_q || (keep && !push));
   end
   always_comb begin
      o_mem_wr_valid = !empty;
      pop = o_mem_wr_valid && i_mem_wr_ready;
      o_mem_wr_addr = head.addr;
      o_mem_wr_data = head.data;
      o_busy = state_q != IDLE;
      o_frame_done = state_q == DRAIN && count == '0;
      o_overflow = ovf_q;
   end
endmodule

// File: tb/tb_conv_result_writer.sv
// tb_conv_result_writer: randomized bench with a queue-based reference model for conv_result_writer
module tb_conv_result_writer;
   localparam int W = 5, H = 4, N = 3, D = 4, DW = 12, OW = 12, AW = 19;
   logic clk = 0, rst = 1, start = 0, vv = 0, rdy = 1;
   logic [DW+2:0] val = '0;
   logic wv, busy, done, ovf;
   logic [AW-1:0] wa;
   logic [OW-1:0] wd;
   always #5 clk = ~clk;
   conv_result_writer #(
      .N(N), .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H),
      .OUT_WIDTH(OW), .ADDR_WIDTH(AW), .FIFO_DEPTH(D)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_val_valid(vv), .i_val(val),
      .o_mem_wr_valid(wv), .i_mem_wr_ready(rdy), .o_mem_wr_addr(wa), .o_mem_wr_data(wd),
      .o_busy(busy), .o_frame_done(done), .o_overflow(ovf)
   );
   int n_cmp = 0, n_err = 0;
   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction
   typedef struct {int a; int d;} ent_t;
   ent_t mq[$];
   int m_mode = 0, m_k = 0, m_addr = 0;
   bit m_ovf = 0, live = 0;
   int log_a[$], log_d[$];
   int done_cnt = 0, cyc_n = 0, last_wr = 0, done_at = 0;
   always @(posedge clk) begin : model
      bit pop;
      int r, c;
      ent_t e;
      live = 1;
      cyc_n++;
      if (wv && rdy) begin
         log_a.push_back(int'(wa));
         log_d.push_back(int'(wd));
         last_wr = cyc_n;
      end
      if (done) begin
         done_cnt++;
         done_at = cyc_n;
      end
      if (rst) begin
         m_mode = 0; m_k = 0; m_addr = 0; m_ovf = 0;
         mq.delete();
      end else begin
         pop = mq.size() > 0 && rdy;
         if (m_mode == 0) begin
            if (start) begin
               m_mode = 1; m_k = 0; m_addr = 0; m_ovf = 0;
            end
         end else if (m_mode == 1) begin
            if (vv) begin
               r = m_k / W;
               c = m_k % W;
               if (r >= N - 1 && c >= N - 1) begin
                  e.a = m_addr;
                  e.d = val > 4095 ? 4095 : int'(val);
                  m_addr++;
                  if (mq.size() < D || pop) mq.push_back(e);
                  else m_ovf = 1;
               end
               m_k++;
               if (m_k == W * H) m_mode = 2;
            end
         end else if (mq.size() == 0) m_mode = 0;
         if (pop) void'(mq.pop_front());
      end
   end
   always @(negedge clk) if (live) begin
      chk("valid", wv, mq.size() > 0);
      if (mq.size() > 0) begin
         chk("addr", wa, mq[0].a);
         chk("data", wd, mq[0].d);
      end
      chk("busy", busy, m_mode != 0);
      chk("frame_done", done, m_mode == 2 && mq.size() == 0);
      chk("overflow", ovf, m_ovf);
   end
   int rdy_mode = 0;
   always @(negedge clk)
      rdy = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : (!rdy ? 1'b1 : $urandom_range(0, 3) != 0);
   logic [DW+2:0] vals [W*H];
   int s1_d [6] = '{12, 13, 14, 17, 18, 19};
   task automatic cyc(input logic v, input logic [DW+2:0] x, input logic s);
      @(negedge clk);
      vv = v;
      val = x;
      start = s;
   endtask
   task automatic run_frame(input bit gaps, input int mid_start);
      int k = 0;
      cyc(0, '0, 1);
      while (k < W * H) begin
         if (gaps && $urandom_range(0, 2) == 0) cyc(0, '0, 0);
         else begin
            cyc(1, vals[k], k == mid_start);
            k++;
         end
      end
      cyc(0, '0, 0);
   endtask
   task automatic wait_done(input string tag);
      int d0 = done_cnt;
      for (int i = 0; i < 100 && done_cnt == d0; i++) cyc(0, '0, 0);
      chk({tag, "_done_pulses"}, done_cnt - d0, 1);
      cyc(0, '0, 0);
   endtask
   task automatic check_log(input string tag, input int n, input int d [6]);
      chk({tag, "_write_count"}, log_a.size(), n);
      for (int i = 0; i < n && i < log_a.size(); i++) begin
         chk({tag, "_wr_addr"}, log_a[i], i);
         chk({tag, "_wr_data"}, log_d[i], d[i]);
      end
   endtask
   task automatic clear_log();
      log_a.delete();
      log_d.delete();
   endtask
   initial begin
      int d0;
      for (int k = 0; k < W * H; k++) vals[k] = (DW+3)'(k);
      repeat (2) @(negedge clk);
      rst = 0;
      chk("rst_valid", wv, 0);
      chk("rst_addr", wa, 0);
      chk("rst_data", wd, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", ovf, 0);
      clear_log();
      run_frame(0, -1);
      wait_done("s1");
      check_log("s1", 6, s1_d);
      chk("s1_ovf", ovf, 0);
      chk("s1_done_latency", done_at - last_wr, 1);
      vals[12] = 15'd5; vals[13] = 15'h0FFF; vals[14] = 15'h1000;
      vals[17] = 15'h7FFF; vals[18] = 15'd0; vals[19] = 15'h1001;
      clear_log();
      run_frame(0, -1);
      wait_done("s2");
      check_log("s2", 6, '{5, 4095, 4095, 4095, 0, 4095});
      for (int k = 0; k < W * H; k++) vals[k] = (DW+3)'(k);
      clear_log();
      rdy_mode = 1;
      run_frame(0, -1);
      rdy_mode = 0;
      wait_done("s3");
      check_log("s3", 4, s1_d);
      chk("s3_ovf", ovf, 1);
      chk("s3_done_after_last_write", done_at - last_wr, 1);
      clear_log();
      rdy_mode = 2;
      run_frame(1, -1);
      wait_done("s4");
      rdy_mode = 0;
      check_log("s4", 6, s1_d);
      chk("s4_ovf", ovf, 0);
      clear_log();
      d0 = done_cnt;
      cyc(0, '0, 1);
      for (int k = 0; k < 10; k++) cyc(1, vals[k], 0);
      @(negedge clk);
      vv = 0;
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("s5_valid", wv, 0);
      chk("s5_busy", busy, 0);
      chk("s5_done", done, 0);
      chk("s5_ovf", ovf, 0);
      repeat (3) cyc(0, '0, 0);
      chk("s5_no_writes", log_a.size(), 0);
      chk("s5_no_done", done_cnt - d0, 0);
      run_frame(0, -1);
      wait_done("s5");
      check_log("s5", 6, s1_d);
      clear_log();
      for (int k = 0; k < 6; k++) cyc(1, 15'(k + 100), 0);
      chk("s6_idle_busy", busy, 0);
      run_frame(0, 7);
      wait_done("s6");
      check_log("s6", 6, s1_d);
      repeat (3) cyc(0, '0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
